intr_ctrl_lite: RTL
===================

// Module: intr_ctrl_lite
// PURPOSE
//  8-input vectored interrupt controller that feeds the Intel8088 INTR pin and answers its INTA cycles.
//  Latches IRQ edges, applies the mask and fixed priority, and raises INTR.
//  Returns an 8-bit vector on the 2nd INTA pulse. Mask/EOI/status registers are I/O-mapped through an IO chip-select.
// PARAMETERS
//  NUM_IRQ      8      number of request inputs (1..8); IRQ0 highest priority
//  VECTOR_BASE  8'h08  vector = VECTOR_BASE + irq index; low 3 bits must be 0
// PORTS
//  CLK      in   1        bus clock, same as Intel8088 CLK
//  RESET    in   1        asynchronous, active-low reset (top connects ~RESET)
//  IRQ      in   NUM_IRQ  async requests, rising-edge triggered
//  INTA     in   1        8088 interrupt acknowledge, active-low
//  INTR     out  1        interrupt request to 8088, active-high
//  CS       in   1        IO chip select from the address decoder, active-low
//  A0       in   1        latched Address[0]: register select
//  RD       in   1        bus read strobe, active-low
//  WR       in   1        bus write strobe, active-low
//  DIN      in   8        data bus in (transceiver side)
//  DOUT     out  8        data bus out
//  DOE      out  1        DOUT drive enable; top tri-states the bus when 0
// BEHAVIOUR
//  Reset: INTR=0, DOE=0, DOUT=0, IRR=0, ISR=0, IMR=8'hFF (all masked), RSEL=IRR, FSM=IDLE.
//  IRQ path: 2-flop sync per bit; a sync 0->1 sets IRR[i] on the next CLK. Further edges while IRR[i]=1 are lost.
//  pend = IRR & ~IMR; hp = lowest-index set bit of pend; hs = lowest-index set bit of ISR.
//  INTR = 1 when pend!=0 and (ISR==0 or hp<hs), i.e. fully nested. It is registered, so it changes 1 CLK after the cause.
//  INTA FSM (INTA sampled on posedge CLK):
//   IDLE: INTA falling -> ACK1. If pend is valid, latch idx=hp, clear IRR[idx], set ISR[idx];
//         else latch idx=7 and flag spurious (ISR untouched).
//   ACK1: INTR forced 0; INTA rising -> WAIT2.
//   WAIT2: INTA falling -> ACK2.
//   ACK2: DOE=1, DOUT=VECTOR_BASE|idx for the whole low time; INTA rising -> IDLE, DOE=0 on that same edge.
//  IRQ edges during ACK1..ACK2 still set IRR. idx is frozen after the 1st INTA.
//  Register writes act on the WR 0->1 edge when CS=0:
//   A0=1: IMR<=DIN. Masking a bit that is already in ISR does not clear ISR.
//   A0=0, DIN=8'h20: non-specific EOI, clears ISR[hs]; no-op if ISR=0.
//   A0=0, DIN=8'b0110_0nnn: specific EOI, clears ISR[nnn].
//   A0=0, DIN=8'h0A / 8'h0B: RSEL <= IRR / ISR.
//   Any other A0=0 value is ignored.
//  Reads: while CS=0 and RD=0 (and FSM not ACK2): DOE=1, DOUT = A0 ? IMR : (RSEL ? ISR : IRR).
//         Otherwise DOE=0. A read has no side effects.
//  Simultaneous events: the 1st INTA edge and an EOI write in the same CLK -> apply the EOI first, then evaluate pend/hp.
//   IRQ set and INTA clear of the same bit in the same CLK -> the bit stays cleared; the edge is consumed.
//  Bits >= NUM_IRQ of IRR/ISR read 0 and never assert.
//  RESET asserted mid-cycle (including during ACK2) -> everything returns to reset values immediately; DOE drops asynchronously.
// CONFIGURATION
//  AUTO_EOI_EN defined: ISR[idx] is cleared at the INTA rising edge that ends ACK2, so ISR only blocks during acknowledge.
//   EOI writes are accepted but have no effect.
//  Undefined: ISR is held until software issues an EOI (default).
// TESTING
//  1. Reset, write IMR=8'hFE, pulse IRQ0 -> INTR=1 within 4 CLK; two INTA pulses -> DOUT=8'h08 with DOE=1 on the 2nd pulse only.
//     Then INTR=0 and ISR=8'h01.
//  2. IMR=0, IRQ3 and IRQ5 raised together -> 1st ack returns 8'h0B; write 8'h20 -> INTR re-asserts; 2nd ack returns 8'h0D.
//  3. Nesting: IRQ4 in service (ISR=8'h10) -> IRQ6 gives no INTR; IRQ1 -> INTR=1, vector 8'h09, ISR=8'h12.
//  4. IRQ2 pending, then IMR=8'h04 written between INTR and the 1st INTA -> vector 8'h0F (spurious); ISR unchanged.
//  5. Write 8'h0B then read A0=0 -> ISR value; write 8'h0A -> IRR value; A0=1 read -> IMR; DOE=0 whenever CS=1.
//  6. Drop RESET during ACK2 -> DOE=0 and INTR=0 at once, IMR=8'hFF. With AUTO_EOI_EN: ISR=0 after the 2nd INTA, no EOI needed.

Source files
------------

// File: rtl/intr_ctrl_lite_if.sv
// Bus bundle between the 8088 side (master) and the interrupt controller (slave).
interface intr_ctrl_lite_if #(
    parameter int NUM_IRQ = 8
);
    logic [NUM_IRQ-1:0] irq;
    logic               inta;
    logic               intr;
    logic               cs;
    logic               a0;
    logic               rd;
    logic               wr;
    logic [7:0]         din;
    logic [7:0]         dout;
    logic               doe;

    modport master (
        output irq, inta, cs, a0, rd, wr, din,
        input  intr, dout, doe
    );

    modport slave (
        input  irq, inta, cs, a0, rd, wr, din,
        output intr, dout, doe
    );
endinterface

// File: rtl/intr_ctrl_lite.sv
// Vectored 8-input interrupt controller for the 8088 INTR/INTA protocol.
// Optional macro AUTO_EOI_EN: clear the in-service bit at the end of the 2nd INTA pulse.
module intr_ctrl_lite #(
    parameter int         NUM_IRQ     = 8,
    parameter logic [7:0] VECTOR_BASE = 8'h08
) (
    input  logic            clk,
    input  logic            rst_n,
    intr_ctrl_lite_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACK1, WAIT2, ACK2} state_t;

    localparam logic [7:0] VALID = 8'((16'd1 << NUM_IRQ) - 16'd1);

    logic [7:0] irq_s1, irq_s2, irq_s3;
    logic [7:0] irr, isr, imr;
    logic       inta_q, wr_q, rsel, intr_q;
    logic [2:0] idx;
    state_t     state;

    logic [7:0] irq_w, rise, pend, isr_eoi, irr_n, isr_n;
    logic [3:0] hp, hs;
    logic       inta_fall, inta_rise, wr_stb, intr_cond;
    state_t     state_n;

    // Returns 8 when no bit is set, so "hp < hs" also covers an empty ISR.
    function automatic logic [3:0] lowest(input logic [7:0] v);
        lowest = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) lowest = 4'(i);
        end
    endfunction

    assign irq_w     = 8'(bus.irq);
    assign inta_fall = inta_q & ~bus.inta;
    assign inta_rise = ~inta_q & bus.inta;
    assign wr_stb    = ~wr_q & bus.wr & ~bus.cs;
    assign rise      = irq_s2 & ~irq_s3 & VALID;
    assign pend      = irr & ~imr;
    assign hp        = lowest(pend);
    assign hs        = lowest(isr);
    assign intr_cond = (pend != 8'h00) && (hp < hs);

    // EOI is applied before the acknowledge sets its ISR bit; the ack clear of IRR wins over a new edge.
    always_comb begin
        isr_eoi = isr;
`ifdef AUTO_EOI_EN
`else
        if (wr_stb && !bus.a0) begin
            if (bus.din == 8'h20) begin
                if (hs < 4'd8) isr_eoi[hs[2:0]] = 1'b0;
            end else if (bus.din[7:3] == 5'b01100) begin
                isr_eoi[bus.din[2:0]] = 1'b0;
            end
        end
`endif
        irr_n   = irr | rise;
        isr_n   = isr_eoi;
        state_n = state;
        case (state)
            IDLE: begin
                if (inta_fall) begin
                    state_n = ACK1;
                    if (pend != 8'h00) begin
                        irr_n[hp[2:0]] = 1'b0;
                        isr_n[hp[2:0]] = 1'b1;
                    end
                end
            end
            ACK1:  if (inta_rise) state_n = WAIT2;
            WAIT2: if (inta_fall) state_n = ACK2;
            ACK2: begin
                if (inta_rise) begin
                    state_n = IDLE;
`ifdef AUTO_EOI_EN
                    isr_n[idx] = 1'b0;
`endif
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_s1 <= 8'h00;
            irq_s2 <= 8'h00;
            irq_s3 <= 8'h00;
            inta_q <= 1'b1;
            wr_q   <= 1'b1;
            irr    <= 8'h00;
            isr    <= 8'h00;
            imr    <= 8'hFF;
            rsel   <= 1'b0;
            idx    <= 3'd0;
            intr_q <= 1'b0;
            state  <= IDLE;
        end else begin
            irq_s1 <= irq_w;
            irq_s2 <= irq_s1;
            irq_s3 <= irq_s2;
            inta_q <= bus.inta;
            wr_q   <= bus.wr;
            irr    <= irr_n & VALID;
            isr    <= isr_n & VALID;
            state  <= state_n;
            intr_q <= intr_cond && (state_n != ACK1);
            if (state == IDLE && inta_fall) begin
                idx <= (pend != 8'h00) ? hp[2:0] : 3'd7;
            end
            if (wr_stb) begin
                if (bus.a0) begin
                    imr <= bus.din;
                end else if (bus.din == 8'h0A) begin
                    rsel <= 1'b0;
                end else if (bus.din == 8'h0B) begin
                    rsel <= 1'b1;
                end
            end
        end
    end

    assign bus.intr = intr_q;

    // Gated with reset so the data bus is released the instant reset asserts.
    always_comb begin
        bus.doe  = 1'b0;
        bus.dout = 8'h00;
        if (rst_n) begin
            if (state == ACK2) begin
                bus.doe  = 1'b1;
                bus.dout = VECTOR_BASE | {5'b00000, idx};
            end else if (!bus.cs && !bus.rd) begin
                bus.doe  = 1'b1;
                bus.dout = bus.a0 ? imr : (rsel ? isr : irr);
            end
        end
    end
endmodule
